// File: rtl/video_fetch_sched.sv
// Video fetch scheduler: issues credit-limited DRAM read requests on pixel-slot
// strobes and buffers returned words in a 4-entry first-word-fall-through FIFO.
module video_fetch_sched #(
    parameter int ADDR_W = 21,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cend,
    input  logic              frame_start,
    input  logic              fetch_en,
    input  logic [1:0]        mode_bw,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              video_req,
    output logic [ADDR_W-1:0] video_addr,
    input  logic              video_next,
    input  logic              video_strobe,
    input  logic [15:0]       video_data,
    input  logic              rd,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              underrun
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state, state_next;
    logic [2:0]  slot;
    logic [2:0]  inflight, inflight_next;
    logic [2:0]  discard;
    logic [2:0]  fifo_count;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [15:0] mem [DEPTH];
    logic        armed;
    logic        slot_hit, eligible, accept, strobe_ret;
    logic        push, pop, fifo_full;
    logic [3:0]  credit;

    always_comb begin
        slot_hit = 1'b0;
        unique case (mode_bw)
            2'b00: slot_hit = (slot == 3'd0);
            2'b01: slot_hit = (slot[1:0] == 2'd0);
            2'b10: slot_hit = (slot[0] == 1'b0);
            2'b11: slot_hit = 1'b1;
        endcase
    end

    // Strobes with nothing outstanding never underflow inflight; armed keeps
    // stale post-reset returns out of the FIFO until a fresh request is accepted.
    assign eligible      = cend & slot_hit;
    assign credit        = {1'b0, fifo_count} + {1'b0, inflight} + {3'b000, video_req};
    assign accept        = (state == PEND) & video_next;
    assign strobe_ret    = video_strobe & (inflight != 3'd0);
    assign inflight_next = inflight + {2'b00, accept} - {2'b00, strobe_ret};
    assign fifo_full     = (fifo_count == 3'(DEPTH));
    assign rd_valid      = (fifo_count != 3'd0);
    assign pop           = rd & rd_valid & ~frame_start;
    assign push          = video_strobe & armed & (discard == 3'd0) & ~frame_start
                           & (~fifo_full | pop);
    assign rd_data       = rd_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (eligible && fetch_en && credit < 4'(DEPTH)) state_next = PEND;
                PEND: if (video_next) state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        video_req = (state == PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= 3'd0;
            video_addr <= '0;
            inflight   <= 3'd0;
            discard    <= 3'd0;
            armed      <= 1'b0;
            underrun   <= 1'b0;
            fifo_count <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
        end else begin
            inflight <= inflight_next;
            armed    <= armed | accept;
            if (rd && !rd_valid) underrun <= 1'b1;
            if (frame_start) begin
                slot       <= 3'd0;
                video_addr <= base_addr;
                discard    <= inflight_next;
                fifo_count <= 3'd0;
                wr_ptr     <= 2'd0;
                rd_ptr     <= 2'd0;
            end else begin
                if (cend) slot <= slot + 3'd1;
                if (accept) video_addr <= video_addr + 1'b1;
                if (video_strobe && discard != 3'd0) discard <= discard - 3'd1;
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= video_data;
    end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Self-checking bench for video_fetch_sched: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_video_fetch_sched;

    logic        clk = 1'b0;
    logic        rst, cend, frame_start, fetch_en;
    logic [1:0]  mode_bw;
    logic [20:0] base_addr;
    logic        video_req;
    logic [20:0] video_addr;
    logic        video_next, video_strobe;
    logic [15:0] video_data;
    logic        rd;
    logic [15:0] rd_data;
    logic        rd_valid, underrun;

    int n_checks = 0;
    int n_pass   = 0;

    video_fetch_sched #(.ADDR_W(21), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cend(cend), .frame_start(frame_start),
        .fetch_en(fetch_en), .mode_bw(mode_bw), .base_addr(base_addr),
        .video_req(video_req), .video_addr(video_addr), .video_next(video_next),
        .video_strobe(video_strobe), .video_data(video_data), .rd(rd),
        .rd_data(rd_data), .rd_valid(rd_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Reference model: pending flag, address, outstanding/discard counts, data queue
    bit          m_pend, m_under, m_armed;
    logic [20:0] m_addr;
    int          m_slot, m_inflight, m_discard;
    logic [15:0] m_q[$];

    task automatic model_step();
        bit elig, acc, ret, pop, full;
        int credit;
        if (rst) begin
            m_pend = 0; m_under = 0; m_armed = 0; m_addr = '0;
            m_slot = 0; m_inflight = 0; m_discard = 0; m_q.delete();
            return;
        end
        elig = cend && (mode_bw == 2'b11 || (mode_bw == 2'b10 && m_slot % 2 == 0) ||
                        (mode_bw == 2'b01 && m_slot % 4 == 0) || (mode_bw == 2'b00 && m_slot == 0));
        credit = m_q.size() + m_inflight + (m_pend ? 1 : 0);
        acc = m_pend && video_next;
        ret = video_strobe && m_inflight > 0;
        if (rd && m_q.size() == 0) m_under = 1;
        if (frame_start) begin
            m_slot = 0; m_q.delete(); m_addr = base_addr; m_pend = 0;
            m_inflight = m_inflight + acc - ret;
            m_discard = m_inflight;
        end else begin
            m_slot = cend ? (m_slot + 1) % 8 : m_slot;
            pop  = rd && m_q.size() > 0;
            full = m_q.size() == 4;
            if (pop) void'(m_q.pop_front());
            if (video_strobe && m_discard > 0) m_discard--;
            else if (video_strobe && m_armed && (!full || pop)) m_q.push_back(video_data);
            if (m_pend) begin
                if (video_next) begin m_pend = 0; m_addr = m_addr + 1; end
            end else if (elig && fetch_en && credit < 4) begin
                m_pend = 1;
            end
            m_inflight = m_inflight + acc - ret;
        end
        if (acc) m_armed = 1;
    endtask

    task automatic set_in(input logic c, input logic fe, input logic [1:0] bw, input logic nx,
                          input logic st, input logic [15:0] d, input logic r, input logic fs);
        cend = c; fetch_en = fe; mode_bw = bw; video_next = nx;
        video_strobe = st; video_data = d; rd = r; frame_start = fs;
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic req, input logic [20:0] addr,
                             input logic valid, input logic [15:0] data, input logic und);
        check_output({tag, ".video_req"}, 32'(video_req), 32'(req));
        check_output({tag, ".video_addr"}, 32'(video_addr), 32'(addr));
        check_output({tag, ".rd_valid"}, 32'(rd_valid), 32'(valid));
        check_output({tag, ".rd_data"}, 32'(rd_data), 32'(data));
        check_output({tag, ".underrun"}, 32'(underrun), 32'(und));
    endtask

    typedef struct {
        logic        cend, fe, nx, st;
        logic [15:0] data;
        logic        exp_req;
        logic [20:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int accepts, exp_k;
        logic p1, p2, nx;

        // Full-rate fetch with immediate grant and 2-cycle data return; stalls at 4 credits
        vecs[0]  = '{1, 1, 0, 0, 16'h0000, 1, 21'h100, 0, 16'h0000};
        vecs[1]  = '{1, 1, 1, 0, 16'h0000, 0, 21'h101, 0, 16'h0000};
        vecs[2]  = '{1, 1, 0, 0, 16'h0000, 1, 21'h101, 0, 16'h0000};
        vecs[3]  = '{1, 1, 1, 1, 16'hA000, 0, 21'h102, 1, 16'hA000};
        vecs[4]  = '{1, 1, 0, 0, 16'h0000, 1, 21'h102, 1, 16'hA000};
        vecs[5]  = '{1, 1, 1, 1, 16'hA001, 0, 21'h103, 1, 16'hA000};
        vecs[6]  = '{1, 1, 0, 0, 16'h0000, 1, 21'h103, 1, 16'hA000};
        vecs[7]  = '{1, 1, 1, 1, 16'hA002, 0, 21'h104, 1, 16'hA000};
        vecs[8]  = '{1, 1, 0, 0, 16'h0000, 0, 21'h104, 1, 16'hA000};
        vecs[9]  = '{1, 1, 0, 1, 16'hA003, 0, 21'h104, 1, 16'hA000};
        vecs[10] = '{1, 1, 0, 0, 16'h0000, 0, 21'h104, 1, 16'hA000};
        vecs[11] = '{1, 1, 0, 0, 16'h0000, 0, 21'h104, 1, 16'hA000};

        rst = 1; base_addr = 21'h100;
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 0, 0);
        apply_stimulus(); apply_stimulus();
        check_all("reset", 0, 21'h0, 0, 16'h0, 0);
        rst = 0;
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 0, 1);
        apply_stimulus();
        check_all("frame_load", 0, 21'h100, 0, 16'h0, 0);

        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].cend, vecs[i].fe, 2'b11, vecs[i].nx, vecs[i].st, vecs[i].data, 0, 0);
            apply_stimulus();
            check_output($sformatf("vec%0d.video_req", i), 32'(video_req), 32'(vecs[i].exp_req));
            check_output($sformatf("vec%0d.video_addr", i), 32'(video_addr), 32'(vecs[i].exp_addr));
            check_output($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
        end

        // Push and pop together on a full FIFO, then drain to prove it stayed at 4
        set_in(0, 0, 2'b11, 0, 1, 16'hA004, 1, 0);
        apply_stimulus();
        check_all("full_pushpop", 0, 21'h104, 1, 16'hA001, 0);
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 1, 0);
        apply_stimulus(); check_output("drain1", 32'(rd_data), 32'hA002);
        apply_stimulus(); check_output("drain2", 32'(rd_data), 32'hA003);
        apply_stimulus(); check_output("drain3", 32'(rd_data), 32'hA004);
        check_output("drain3.valid", 32'(rd_valid), 32'h1);
        apply_stimulus(); check_output("drain4.valid", 32'(rd_valid), 32'h0);

        // Pop on empty sets a sticky underrun
        apply_stimulus();
        check_all("underrun_set", 0, 21'h104, 0, 16'h0, 1);
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 0, 0);
        repeat (5) apply_stimulus();
        check_all("underrun_sticky", 0, 21'h104, 0, 16'h0, 1);
        rst = 1; apply_stimulus(); rst = 0;
        check_all("underrun_clear", 0, 21'h0, 0, 16'h0, 0);

        // Frame restart with two reads outstanding: both returns discarded
        base_addr = 21'h200;
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 0, 1); apply_stimulus();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 2'b11, 0, 0, 16'h0, 0, 0); apply_stimulus();
            set_in(1, 1, 2'b11, 1, 0, 16'h0, 0, 0); apply_stimulus();
        end
        check_output("pre_restart.addr", 32'(video_addr), 32'h202);
        base_addr = 21'h1000;
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 0, 1); apply_stimulus();
        check_all("restart", 0, 21'h1000, 0, 16'h0, 0);
        set_in(0, 0, 2'b11, 0, 1, 16'hBEEF, 0, 0); apply_stimulus();
        check_output("discard1.valid", 32'(rd_valid), 32'h0);
        apply_stimulus();
        check_output("discard2.valid", 32'(rd_valid), 32'h0);
        set_in(1, 1, 2'b11, 0, 0, 16'h0, 0, 0); apply_stimulus();
        check_all("restart_req", 1, 21'h1000, 0, 16'h0, 0);
        set_in(0, 0, 2'b11, 1, 0, 16'h0, 0, 0); apply_stimulus();
        set_in(0, 0, 2'b11, 0, 1, 16'hC0DE, 0, 0); apply_stimulus();
        check_all("restart_data", 0, 21'h1001, 1, 16'hC0DE, 0);
        set_in(0, 0, 2'b11, 0, 0, 16'h0, 1, 0); apply_stimulus();

        // Reset during a pending request with three reads in flight
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 2'b11, 0, 0, 16'h0, 0, 0); apply_stimulus();
            set_in(1, 1, 2'b11, 1, 0, 16'h0, 0, 0); apply_stimulus();
        end
        set_in(1, 1, 2'b11, 0, 0, 16'h0, 0, 0); apply_stimulus();
        check_output("pend3.req", 32'(video_req), 32'h1);
        rst = 1;
        set_in(1, 1, 2'b11, 1, 1, 16'h1111, 1, 1); apply_stimulus();
        rst = 0;
        check_all("rst_override", 0, 21'h0, 0, 16'h0, 0);
        set_in(0, 0, 2'b11, 0, 1, 16'h2222, 0, 0);
        repeat (3) apply_stimulus();
        check_all("stale_strobes", 0, 21'h0, 0, 16'h0, 0);

        // Lowest bandwidth over 64 slots with a continuously draining consumer
        rst = 1; apply_stimulus(); rst = 0;
        base_addr = 21'h300;
        set_in(0, 0, 2'b00, 0, 0, 16'h0, 0, 1); apply_stimulus();
        accepts = 0; exp_k = 0; p1 = 0; p2 = 0;
        for (int c = 0; c < 72; c++) begin
            nx = video_req;
            if (nx) begin
                check_output("bw00.addr", 32'(video_addr), 32'(21'h300 + exp_k));
                exp_k++;
                accepts++;
            end
            set_in(c < 64, 1, 2'b00, nx, p2, 16'(c), 1, 0);
            apply_stimulus();
            p2 = p1; p1 = nx;
        end
        check_output("bw00.requests", 32'(accepts), 32'd8);

        // Randomized run against the reference model
        rst = 1; set_in(0, 0, 2'b00, 0, 0, 16'h0, 0, 0); apply_stimulus(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 399) == 0);
            frame_start = ($urandom_range(0, 63) == 0);
            base_addr   = 21'($urandom);
            cend        = $urandom_range(0, 1) == 1;
            fetch_en    = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 31) == 0) mode_bw = 2'($urandom);
            video_next   = m_pend && ($urandom_range(0, 2) != 0);
            video_strobe = (m_inflight > 0) && ($urandom_range(0, 1) == 1);
            video_data   = 16'($urandom);
            rd           = $urandom_range(0, 1) == 1;
            apply_stimulus();
            check_all("rand", m_pend, m_addr, m_q.size() > 0,
                      (m_q.size() > 0) ? m_q[0] : 16'h0, m_under);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_fetch_sched.md
VIDEO_FETCH_SCHED -- requirements
Module: video_fetch_sched

Interface
REQ-001 Parameter ADDR_W, default 21: width of the DRAM word address.
REQ-002 Parameter DEPTH, fixed at 4: number of entries in the fetch FIFO, which also sets the credit limit.
REQ-003 clk  in  1  single system clock; all logic is clocked on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cend  in  1  one-cycle pixel-slot strobe; the slot counter advances only on this strobe.
REQ-006 frame_start  in  1  one-cycle strobe marking the start of a frame.
REQ-007 fetch_en  in  1  high while the fetch window is open.
REQ-008 mode_bw  in  2  required bandwidth from the mode decoder: 00 = 1/8, 01 = 1/4, 10 = 1/2, 11 = 1.
REQ-009 base_addr  in  ADDR_W  start address of the frame, loaded on frame_start.
REQ-010 video_req  out  1  request level to the DRAM arbiter.
REQ-011 video_addr  out  ADDR_W  address of the current request.
REQ-012 video_next  in  1  one-cycle arbiter acceptance of the pending request.
REQ-013 video_strobe  in  1  one-cycle strobe: read data for the oldest accepted request is valid.
REQ-014 video_data  in  16  DRAM read data.
REQ-015 rd  in  1  consumer pop request.
REQ-016 rd_data  out  16  head entry of the FIFO (first-word-fall-through).
REQ-017 rd_valid  out  1  FIFO is not empty.
REQ-018 underrun  out  1  sticky flag: a pop was attempted while the FIFO was empty.

Function
REQ-019 Slot counter slot[2:0] SHALL increment modulo 8 on each cend and SHALL be cleared to 0 by frame_start, which takes priority over cend.
REQ-020 An eligible slot SHALL be a cend cycle meeting the mode_bw condition:
- bw=00: slot==0
- bw=01: slot[1:0]==0
- bw=10: slot[0]==0
- bw=11: every slot
REQ-021 The credit sum SHALL be fifo_count + inflight + (video_req ? 1 : 0).
REQ-022 Request FSM states SHALL be IDLE and PEND; reset state is IDLE.
REQ-023 IDLE -> PEND on an eligible slot when fetch_en=1 and the credit sum < DEPTH; video_req SHALL be high starting the next cycle.
REQ-024 PEND: video_req SHALL stay high and video_addr SHALL stay stable until video_next.
REQ-025 On video_next in PEND, the FSM SHALL return to IDLE, inflight SHALL increment, and video_addr SHALL increment by 1 in the following cycle.
REQ-026 An eligible slot occurring while in PEND SHALL be dropped; requests are never queued.
REQ-027 video_next while in IDLE SHALL be ignored.
REQ-028 Deasserting fetch_en SHALL not cancel a PEND request; it only blocks new requests.
REQ-029 video_strobe SHALL decrement inflight; if the discard counter is 0, video_data SHALL be written to the FIFO tail.
REQ-030 Credit accounting SHALL guarantee a write never hits a full FIFO; no overflow path is required.
REQ-031 On rd with rd_valid=1, the FIFO SHALL advance its head pointer.
REQ-032 A simultaneous push and pop SHALL leave fifo_count unchanged, including when fifo_count=DEPTH-1 or DEPTH.
REQ-033 rd while rd_valid=0 SHALL set underrun and leave FIFO state unchanged; underrun is cleared only by rst.
REQ-034 frame_start SHALL, in one cycle:
- load video_addr with base_addr
- force the FSM to IDLE and drop video_req
- empty the FIFO
- copy inflight, plus 1 if video_next arrives in that same cycle, into the discard counter
REQ-035 Each video_strobe arriving while discard > 0 SHALL decrement discard and SHALL not write the FIFO.
REQ-036 inflight and discard SHALL each be 3 bits wide and SHALL never exceed DEPTH.
REQ-037 FIFO pointers SHALL be 2 bits wide and wrap modulo 4; fifo_count SHALL be 3 bits wide.
REQ-038 A mode_bw change SHALL take effect at the next cend; slot SHALL not be reset by the change.

Reset
REQ-039 On rst=1, outputs SHALL be: video_req=0, video_addr=0, rd_valid=0, rd_data=0, underrun=0.
REQ-040 On rst=1, internal state SHALL be: slot=0, FSM=IDLE, inflight=0, discard=0, fifo_count=0, both FIFO pointers=0.
REQ-041 rst SHALL override every other input in the same cycle, including frame_start, video_next and video_strobe.

Verification
REQ-042 Stimulus: bw=11, cend every cycle, fetch_en=1, arbiter grants immediately, data returns 2 cycles after grant, rd=0. Required: 4 requests at addresses base..base+3, then video_req stays low with fifo_count=4.
REQ-043 Stimulus: bw=00, 64 cend strobes, consumer drains continuously. Required: exactly 8 requests issued, one per slot 0.
REQ-044 Stimulus: frame_start with 2 requests in flight and base_addr=0x1000. Required: the 2 late strobes are discarded, FIFO is empty, next video_addr=0x1000.
REQ-045 Stimulus: rd pulsed while the FIFO is empty. Required: underrun=1 and stays 1 until rst, fifo_count stays 0.
REQ-046 Stimulus: fifo_count=4 with rd and video_strobe in the same cycle. Required: fifo_count=4 afterwards and data order preserved (FIFO order).
REQ-047 Stimulus: rst asserted during PEND with inflight=3. Required: all REQ-039 and REQ-040 values on the next edge, and no FIFO write from subsequent strobes until a new request is accepted.
